// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480@60 default timing, derived totals and border geometry shared with the game logic
package vga_pkg;

    localparam int PIX_DIV    = 2;
    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    localparam int H_TOTAL = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef logic [10:0] xpos_t;
    typedef logic [9:0]  ypos_t;

    localparam xpos_t BORDER_X0 = 11'd40;
    localparam xpos_t BORDER_X1 = 11'd600;
    localparam ypos_t BORDER_Y0 = 10'd60;
    localparam ypos_t BORDER_Y1 = 10'd420;

    // One-pixel rectangle outline; the corners belong to both a column and a row.
    function automatic logic on_border(input xpos_t x, input ypos_t y);
        logic on_col;
        logic on_row;
        on_col = ((x == BORDER_X0) || (x == BORDER_X1)) && (y >= BORDER_Y0) && (y <= BORDER_Y1);
        on_row = ((y == BORDER_Y0) || (y == BORDER_Y1)) && (x >= BORDER_X0) && (x <= BORDER_X1);
        return on_col || on_row;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with wrap, active flag and sync window
module vga_axis_counter #(
    parameter int VIS  = 640,
    parameter int FP   = 16,
    parameter int SYNC = 96,
    parameter int BP   = 48,
    parameter int W    = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o,
    output logic         active_o,
    output logic         sync_o
);

    localparam int TOTAL = VIS + FP + SYNC + BP;

    // All limits held at counter width so every compare is full width.
    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] VIS_W   = W'(VIS);
    localparam logic [W-1:0] SYNC_LO = W'(VIS + FP);
    localparam logic [W-1:0] SYNC_HI = W'(VIS + FP + SYNC - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign last_o   = (cnt_q == LAST);
    assign active_o = (cnt_q < VIS_W);
    assign sync_o   = (cnt_q >= SYNC_LO) && (cnt_q <= SYNC_HI);

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster generator with registered sync/colour pins; VGA_BORDER_EN adds a white frame outline
module vga_timing
    import vga_pkg::*;
#(
    parameter int DIV    = PIX_DIV,
    parameter int H_VIS  = H_VIS_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_VIS  = V_VIS_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_red,
    input  logic        game_green,
    input  logic        game_blue,
    output logic [10:0] vga_xpos,
    output logic [9:0]  vga_ypos,
    output logic        pix_en,
    output logic        frame_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_r,
    output logic        vga_g,
    output logic        vga_b
);

    logic h_last;
    logic h_active;
    logic h_sync;
    logic v_last;
    logic v_active;
    logic v_sync;
    logic v_en;
    logic active;
    logic border;

    // Pixel-rate enable. With DIV == 1 every system clock is a pixel.
    generate
        if (DIV > 1) begin : g_div
            localparam int DW = $clog2(DIV);
            localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

            logic [DW-1:0] div_cnt_q;
            logic [DW-1:0] div_cnt_d;

            always_comb begin
                div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    div_cnt_q <= '0;
                end else begin
                    div_cnt_q <= div_cnt_d;
                end
            end

            assign pix_en = (div_cnt_q == DIV_LAST);
        end else begin : g_nodiv
            assign pix_en = 1'b1;
        end
    endgenerate

    vga_axis_counter #(
        .VIS  (H_VIS),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .W    (11)
    ) u_h (
        .clk      (clk),
        .rst      (rst),
        .en_i     (pix_en),
        .cnt_o    (vga_xpos),
        .last_o   (h_last),
        .active_o (h_active),
        .sync_o   (h_sync)
    );

    // The line counter steps on the same pixel edge that wraps the column counter.
    assign v_en = pix_en & h_last;

    vga_axis_counter #(
        .VIS  (V_VIS),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .W    (10)
    ) u_v (
        .clk      (clk),
        .rst      (rst),
        .en_i     (v_en),
        .cnt_o    (vga_ypos),
        .last_o   (v_last),
        .active_o (v_active),
        .sync_o   (v_sync)
    );

    assign active      = h_active & v_active;
    assign frame_start = pix_en & h_last & v_last;

`ifdef VGA_BORDER_EN
    assign border = on_border(vga_xpos, vga_ypos);
`else
    assign border = 1'b0;
`endif

    logic hs_q;
    logic hs_d;
    logic vs_q;
    logic vs_d;
    logic r_q;
    logic r_d;
    logic g_q;
    logic g_d;
    logic b_q;
    logic b_d;

    // Sync and colour share one register stage fed by the pre-increment
    // counters, so all pins lag the coordinates by exactly one pixel.
    always_comb begin
        hs_d = hs_q;
        vs_d = vs_q;
        r_d  = r_q;
        g_d  = g_q;
        b_d  = b_q;
        if (pix_en) begin
            hs_d = ~h_sync;
            vs_d = ~v_sync;
            r_d  = active & (game_red   | border);
            g_d  = active & (game_green | border);
            b_d  = active & (game_blue  | border);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            r_q  <= 1'b0;
            g_q  <= 1'b0;
            b_q  <= 1'b0;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
        end
    end

    assign vga_hs = hs_q;
    assign vga_vs = vs_q;
    assign vga_r  = r_q;
    assign vga_g  = g_q;
    assign vga_b  = b_q;

endmodule
